// File: rtl/mux_scan_sequencer.sv
// Mask-driven scan of a 16-channel buffer bank through a 16:1 mux into a tagged FWFT FIFO.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS,
    input  logic [15:0] data_in,
    input  logic [7:0]  mux_data,
    input  logic        rd_en,
    output logic [3:0]  mux_sel,
    output logic [15:0] buf_oe,
    output logic [11:0] rd_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        busy,
    output logic        overflow,
    output logic        pass_done
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [3:0] OP_MASK_LO    = 4'h1;
    localparam logic [3:0] OP_MASK_HI    = 4'h2;
    localparam logic [3:0] OP_START      = 4'h3;
    localparam logic [3:0] OP_STOP       = 4'h4;
    localparam logic [3:0] OP_FIFO_CLEAR = 4'h5;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE} state_e;

    state_e           state_q, state_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0]      amask_q, amask_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             cont_q, cont_d;
    logic [3:0]       ch_q, ch_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [3:0]       mux_sel_d;
    logic [15:0]      buf_oe_d;
    logic             busy_d, pass_done_d;

    logic [11:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      rd_data_d;
    logic             fifo_empty_d, fifo_full_d, overflow_d;

    logic [3:0]       op_c;
    logic [7:0]       arg_c;
    logic             sample_c, push_c, pop_c, clear_c;
    logic [4:0]       first_c, next_c;
    logic [11:0]      push_word_c;
    logic             unused_bits;

    // Lowest set bit of m at index >= from; bit 4 flags that one was found.
    function automatic logic [4:0] next_set(input logic [15:0] m, input logic [4:0] from);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign op_c        = CS ? data_in[15:12] : 4'h0;
    assign arg_c       = data_in[7:0];
    assign unused_bits = ^data_in[11:8];
    assign push_word_c = {ch_q, mux_data};

    // Command decode, scan FSM next state and registered mux/buffer controls.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        amask_d     = amask_q;
        pcnt_d      = pcnt_q;
        cont_d      = cont_q;
        ch_d        = ch_q;
        settle_d    = settle_q;
        mux_sel_d   = mux_sel;
        buf_oe_d    = buf_oe;
        pass_done_d = 1'b0;
        sample_c    = 1'b0;
        first_c     = next_set(mask_q, 5'd0);
        next_c      = next_set(amask_q, 5'(ch_q) + 5'd1);

        if (op_c == OP_MASK_LO) mask_d[7:0]  = arg_c;
        if (op_c == OP_MASK_HI) mask_d[15:8] = arg_c;

        case (state_q)
            S_IDLE: begin
                if (op_c == OP_START && mask_q != 16'd0) begin
                    amask_d = mask_q;
                    ch_d    = first_c[3:0];
                    pcnt_d  = arg_c;
                    cont_d  = (arg_c == 8'd0);
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                mux_sel_d = ch_q;
                buf_oe_d  = 16'd1 << ch_q;
                settle_d  = SET_W'(SETTLE_CYC - 1);
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = S_SAMPLE;
                else                settle_d = settle_q - SET_W'(1);
            end
            S_SAMPLE: begin
                sample_c = 1'b1;
                if (next_c[4]) begin
                    ch_d    = next_c[3:0];
                    state_d = S_SELECT;
                end else begin
                    pass_done_d = 1'b1;
                    if ((cont_q || pcnt_q > 8'd1) && first_c[4]) begin
                        if (!cont_q) pcnt_d = pcnt_q - 8'd1;
                        amask_d = mask_q;
                        ch_d    = first_c[3:0];
                        state_d = S_SELECT;
                    end else begin
                        state_d   = S_IDLE;
                        mux_sel_d = 4'd0;
                        buf_oe_d  = 16'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // STOP aborts the current visit without a push or pass_done.
        if (op_c == OP_STOP && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            sample_c    = 1'b0;
            pass_done_d = 1'b0;
            mux_sel_d   = 4'd0;
            buf_oe_d    = 16'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // FIFO pointer/count update; clear wins over push and pop, head kept registered.
    always_comb begin
        clear_c    = (op_c == OP_FIFO_CLEAR);
        pop_c      = rd_en && (cnt_q != '0) && !clear_c;
        push_c     = sample_c && !clear_c && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data;
        overflow_d = overflow;
        if (clear_c) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (sample_c && !push_c) overflow_d = 1'b1;
            if (cnt_d != '0) begin
                rd_data_d = (cnt_q == CNT_W'(pop_c)) ? push_word_c : mem_q[rd_ptr_d];
            end
        end
        fifo_empty_d = (cnt_d == '0);
        fifo_full_d  = (cnt_d == CNT_W'(FIFO_DEPTH));
    end

    // Scan state and control outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            amask_q   <= '0;
            pcnt_q    <= '0;
            cont_q    <= 1'b0;
            ch_q      <= '0;
            settle_q  <= '0;
            mux_sel   <= '0;
            buf_oe    <= '0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            amask_q   <= amask_d;
            pcnt_q    <= pcnt_d;
            cont_q    <= cont_d;
            ch_q      <= ch_d;
            settle_q  <= settle_d;
            mux_sel   <= mux_sel_d;
            buf_oe    <= buf_oe_d;
            busy      <= busy_d;
            pass_done <= pass_done_d;
        end
    end

    // FIFO bookkeeping and status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_data    <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_data    <= rd_data_d;
            fifo_empty <= fifo_empty_d;
            fifo_full  <= fifo_full_d;
            overflow   <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility.
    always_ff @(posedge CLK) begin
        if (push_c) mem_q[wr_ptr_q] <= push_word_c;
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: model predicts FIFO entries, monitor drains and compares.
module tb_mux_scan_sequencer;
    localparam int unsigned SETTLE_CYC = 3;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CH_CYC     = SETTLE_CYC + 2;

    localparam logic [3:0] OP_MASK_LO    = 4'h1;
    localparam logic [3:0] OP_MASK_HI    = 4'h2;
    localparam logic [3:0] OP_START      = 4'h3;
    localparam logic [3:0] OP_STOP       = 4'h4;
    localparam logic [3:0] OP_FIFO_CLEAR = 4'h5;

    logic        CLK, RST_N, CS, rd_en;
    logic [15:0] data_in;
    logic [7:0]  mux_data;
    logic [3:0]  mux_sel;
    logic [15:0] buf_oe;
    logic [11:0] rd_data;
    logic        fifo_empty, fifo_full, busy, overflow, pass_done;

    logic [7:0]  tbl [16];
    logic [11:0] exp_q [$];
    logic [15:0] oe_log [$];
    logic [15:0] last_oe = 16'd0;
    int          tests, fails, pd_cnt, busy_cnt;
    bit          mon_en, mon_rd, force_rd, busy_at_pd;

    // Each buffer presents its table value when selected.
    assign mux_data = tbl[mux_sel];
    assign rd_en    = mon_rd | force_rd;

    mux_scan_sequencer #(.SETTLE_CYC(SETTLE_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .data_in(data_in), .mux_data(mux_data),
        .rd_en(rd_en), .mux_sel(mux_sel), .buf_oe(buf_oe), .rd_data(rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(busy),
        .overflow(overflow), .pass_done(pass_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: event counters plus scoreboard drain of the FIFO head.
    always @(negedge CLK) begin
        mon_rd = 1'b0;
        if (RST_N) begin
            if (pass_done) begin
                pd_cnt++;
                busy_at_pd = busy;
            end
            if (busy) busy_cnt++;
            if (buf_oe != 16'd0 && buf_oe != last_oe) oe_log.push_back(buf_oe);
            last_oe = buf_oe;
            if (mon_en && !fifo_empty) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got 0x%0h, want no entry", rd_data);
                end else begin
                    check("sb_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
                mon_rd = 1'b1;
            end
        end
    end

    task automatic send_cmd(input logic [3:0] op, input logic [7:0] arg);
        @(negedge CLK);
        CS      = 1'b1;
        data_in = {op, 4'($urandom), arg};
        @(posedge CLK);
        #1;
        CS      = 1'b0;
        data_in = 16'd0;
    endtask

    task automatic set_mask(input logic [15:0] m);
        send_cmd(OP_MASK_LO, m[7:0]);
        send_cmd(OP_MASK_HI, m[15:8]);
    endtask

    // One full pass yields every set channel in ascending order.
    task automatic expect_pass(input logic [15:0] m);
        for (int c = 0; c < 16; c++) begin
            if (m[c]) exp_q.push_back({4'(c), tbl[c]});
        end
    endtask

    // Single pass into an unread FIFO; optionally one host pop coincides with push number pop_at.
    task automatic model_fill(input logic [15:0] m, input int pop_at, output bit ovf);
        logic [11:0] f [$];
        int k;
        k   = 0;
        ovf = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (m[c]) begin
                if (k == pop_at && f.size() != 0) f.delete(0);
                if (f.size() < FIFO_DEPTH) f.push_back({4'(c), tbl[c]});
                else ovf = 1'b1;
                k++;
            end
        end
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic gap();
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mux_sel"},   32'(mux_sel),    32'd0);
        check({tag, "_buf_oe"},    32'(buf_oe),     32'd0);
        check({tag, "_rd_data"},   32'(rd_data),    32'd0);
        check({tag, "_empty"},     32'(fifo_empty), 32'd1);
        check({tag, "_full"},      32'(fifo_full),  32'd0);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_overflow"},  32'(overflow),   32'd0);
        check({tag, "_pass_done"}, 32'(pass_done),  32'd0);
    endtask

    initial begin
        logic [15:0] m;
        int np, pd0, b0, s0;
        bit ovf;

        RST_N    = 1'b1;
        CS       = 1'b0;
        data_in  = 16'd0;
        mon_en   = 1'b0;
        force_rd = 1'b0;
        for (int c = 0; c < 16; c++) tbl[c] = 8'hA0 + 8'(c);
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("rst");
        @(negedge CLK);
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // Single pass over channels 0 and 2.
        set_mask(16'h0005);
        expect_pass(16'h0005);
        pd0 = pd_cnt; b0 = busy_cnt; s0 = oe_log.size();
        send_cmd(OP_START, 8'd1);
        wait_idle(200);
        wait_drain(50);
        gap();
        check("sp_pass_done", 32'(pd_cnt - pd0), 32'd1);
        check("sp_busy_cycles", 32'(busy_cnt - b0), 32'(2 * CH_CYC));
        check("sp_busy_at_pd", 32'(busy_at_pd), 32'd0);
        check("sp_oe_count", 32'(oe_log.size() - s0), 32'd2);
        if (oe_log.size() == s0 + 2) begin
            check("sp_oe_first", 32'(oe_log[s0]), 32'h0001);
            check("sp_oe_second", 32'(oe_log[s0 + 1]), 32'h0004);
        end
        check("sp_buf_oe_idle", 32'(buf_oe), 32'd0);
        check("sp_mux_sel_idle", 32'(mux_sel), 32'd0);

        // Random masks, pass counts and buffer data with the host keeping up.
        for (int it = 0; it < 5; it++) begin
            m  = 16'($urandom_range(1, 16'hFFFF));
            np = $urandom_range(1, 2);
            for (int c = 0; c < 16; c++) tbl[c] = 8'($urandom);
            set_mask(m);
            for (int p = 0; p < np; p++) expect_pass(m);
            pd0 = pd_cnt; b0 = busy_cnt;
            send_cmd(OP_START, 8'(np));
            wait_idle(2 * 16 * CH_CYC + 20);
            wait_drain(50);
            gap();
            check("rnd_pass_done", 32'(pd_cnt - pd0), 32'(np));
            check("rnd_busy_cycles", 32'(busy_cnt - b0), 32'(np * $countones(m) * CH_CYC));
            check("rnd_overflow", 32'(overflow), 32'd0);
        end

        // Mask rewritten during pass 1 only takes effect on pass 2.
        set_mask(16'h0003);
        expect_pass(16'h0003);
        expect_pass(16'h0010);
        pd0 = pd_cnt; b0 = busy_cnt;
        send_cmd(OP_START, 8'd2);
        send_cmd(OP_MASK_LO, 8'h10);
        wait_idle(200);
        wait_drain(50);
        gap();
        check("mm_pass_done", 32'(pd_cnt - pd0), 32'd2);
        check("mm_busy_cycles", 32'(busy_cnt - b0), 32'(3 * CH_CYC));

        // Continuous mode, STOP during ch15 settle of the third pass.
        set_mask(16'h8001);
        expect_pass(16'h8001);
        expect_pass(16'h8001);
        exp_q.push_back({4'd0, tbl[0]});
        pd0 = pd_cnt; b0 = busy_cnt;
        send_cmd(OP_START, 8'd0);
        repeat (4 * CH_CYC + CH_CYC + 1) @(posedge CLK);
        #1;
        check("cs_oe_before_stop", 32'(buf_oe), 32'h8000);
        send_cmd(OP_STOP, 8'd0);
        check("cs_busy_after_stop", 32'(busy), 32'd0);
        check("cs_oe_after_stop", 32'(buf_oe), 32'd0);
        check("cs_sel_after_stop", 32'(mux_sel), 32'd0);
        wait_drain(50);
        repeat (2 * CH_CYC) @(posedge CLK);
        #1;
        check("cs_no_more_entries", 32'(fifo_empty), 32'd1);
        check("cs_pass_done", 32'(pd_cnt - pd0), 32'd2);
        check("cs_busy_cycles", 32'(busy_cnt - b0), 32'(5 * CH_CYC + 2));

        // Full FIFO with a pop on the same edge as a push.
        mon_en = 1'b0;
        set_mask(16'h01FF);
        model_fill(16'h01FF, FIFO_DEPTH, ovf);
        send_cmd(OP_START, 8'd1);
        repeat (FIFO_DEPTH * CH_CYC + CH_CYC - 1) @(posedge CLK);
        #1;
        check("cc_full_before", 32'(fifo_full), 32'd1);
        check("cc_ovf_before", 32'(overflow), 32'd0);
        force_rd = 1'b1;
        @(posedge CLK);
        #1;
        force_rd = 1'b0;
        check("cc_full_after", 32'(fifo_full), 32'd1);
        check("cc_ovf_after", 32'(overflow), 32'(ovf));
        wait_idle(50);
        mon_en = 1'b1;
        wait_drain(50);
        gap();
        check("cc_empty_end", 32'(fifo_empty), 32'd1);

        // Overflow with no reads, then FIFO_CLEAR.
        mon_en = 1'b0;
        gap();
        set_mask(16'hFFFF);
        model_fill(16'hFFFF, -1, ovf);
        send_cmd(OP_START, 8'd1);
        wait_idle(16 * CH_CYC + 20);
        gap();
        check("of_overflow", 32'(overflow), 32'(ovf));
        check("of_full", 32'(fifo_full), 32'd1);
        mon_en = 1'b1;
        wait_drain(50);
        gap();
        check("of_empty_drained", 32'(fifo_empty), 32'd1);
        check("of_overflow_sticky", 32'(overflow), 32'd1);
        mon_en = 1'b0;
        gap();
        set_mask(16'h0003);
        send_cmd(OP_START, 8'd1);
        wait_idle(100);
        gap();
        check("clr_nonempty_before", 32'(fifo_empty), 32'd0);
        send_cmd(OP_FIFO_CLEAR, 8'd0);
        check("clr_empty", 32'(fifo_empty), 32'd1);
        check("clr_full", 32'(fifo_full), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset mid-scan, then START with the reset (zero) mask.
        set_mask(16'hFFFF);
        tbl[0] = 8'h5A;
        send_cmd(OP_START, 8'd1);
        repeat (12) @(posedge CLK);
        #1;
        check("ar_head_before", 32'(rd_data), 32'({4'd0, tbl[0]}));
        check("ar_oe_before", 32'(buf_oe), 32'h0004);
        #3 RST_N = 1'b0;
        #1;
        check_reset_vals("ar");
        @(negedge CLK);
        RST_N = 1'b1;
        send_cmd(OP_START, 8'd1);
        check("zs_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("zs_busy_later", 32'(busy), 32'd0);
        check("zs_oe_later", 32'(buf_oe), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
